// File: rtl/pmod_pkg.sv
// ============================================================================
//  pmod_pkg : shared mode encodings and pattern constants for pmod_pattern_gen
//  Rev 1.0
// ============================================================================
`default_nettype none

package pmod_pkg;

    typedef enum logic [1:0] {
        MODE_WALK1  = 2'd0,
        MODE_COUNT  = 2'd1,
        MODE_CHECK  = 2'd2,
        MODE_PORTID = 2'd3
    } mode_t;

    localparam logic [7:0] C_CHECK_SEED = 8'h55;

endpackage

`default_nettype wire

// File: rtl/pmod_pattern_gen_if.sv
// ============================================================================
//  pmod_pattern_gen_if : board-side buttons, PMOD pins and LEDs
//  Rev 1.0
// ============================================================================
`default_nettype none

interface pmod_pattern_gen_if #(
    parameter int PW = 32
);
    logic [1:0]    i_btn;
    logic [PW-1:0] o_pmod;
    logic [1:0]    o_ledg;
    logic          o_ledr;

    modport master (output i_btn, input o_pmod, input o_ledg, input o_ledr);
    modport slave  (input i_btn, output o_pmod, output o_ledg, output o_ledr);
endinterface

`default_nettype wire

// File: rtl/pmod_debounce.sv
// ============================================================================
//  pmod_debounce : 2-FF synchroniser plus stability counter for one button;
//                  emits the settled level and a one-cycle rising-edge pulse
//  Rev 1.0
// ============================================================================
`default_nettype none

module pmod_debounce #(
    parameter int DBBITS = 16
) (
    input  wire logic i_clk,
    input  wire logic i_reset_n,
    input  wire logic i_btn,
    output logic      o_stable,
    output logic      o_press
);
    localparam logic [DBBITS-1:0] C_DB_MAX = '1;

    logic              r_meta;
    logic              r_sync;
    logic              r_stable;
    logic              r_press;
    logic [DBBITS-1:0] r_dbcnt;
    logic              w_settle;

    assign w_settle = (r_sync != r_stable) && (r_dbcnt == C_DB_MAX);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_meta   <= 1'b0;
            r_sync   <= 1'b0;
            r_stable <= 1'b0;
            r_press  <= 1'b0;
            r_dbcnt  <= '0;
        end else begin
            r_meta  <= i_btn;
            r_sync  <= r_meta;
            // Pulse only on a settled release-to-press change
            r_press <= w_settle && r_sync;
            if (r_sync == r_stable) begin
                r_dbcnt <= '0;
            end else if (w_settle) begin
                r_stable <= r_sync;
                r_dbcnt  <= '0;
            end else begin
                r_dbcnt <= r_dbcnt + DBBITS'(1);
            end
        end
    end

    assign o_stable = r_stable;
    assign o_press  = r_press;

endmodule

`default_nettype wire

// File: rtl/pmod_pattern_gen.sv
// ============================================================================
//  pmod_pattern_gen : PMOD exerciser driving a mode-selectable, steppable
//                     test pattern with button control and status LEDs
//  Rev 1.0
// ============================================================================
`default_nettype none

module pmod_pattern_gen
    import pmod_pkg::*;
#(
    parameter int CBITS    = 27,
    parameter int STEPBITS = 22,
    parameter int DBBITS   = 16,
    parameter int NPMOD    = 4
) (
    input  wire logic        i_clk,
    input  wire logic        i_reset_n,
    pmod_pattern_gen_if.slave bus
);
    localparam int            PW    = 8 * NPMOD;
    localparam logic [PW-1:0] C_ONE = PW'(1);

    logic [CBITS-1:0] r_ctr;
    mode_t            r_mode;
    logic             r_run;
    logic             r_load;
    logic [PW-1:0]    r_pattern;
    logic [PW-1:0]    w_seed;
    logic [PW-1:0]    w_next;
    logic [1:0]       w_stable;
    logic [1:0]       w_press;
    logic             w_step;

    generate
        for (genvar b = 0; b < 2; b++) begin : g_btn
            pmod_debounce #(.DBBITS(DBBITS)) u_db (
                .i_clk     (i_clk),
                .i_reset_n (i_reset_n),
                .i_btn     (bus.i_btn[b]),
                .o_stable  (w_stable[b]),
                .o_press   (w_press[b])
            );
        end
    endgenerate

    assign w_step = &r_ctr[STEPBITS-1:0];

    always_comb begin
        w_seed = '0;
        case (r_mode)
            MODE_WALK1: w_seed = C_ONE;
            MODE_COUNT: w_seed = '0;
            MODE_CHECK: w_seed = {NPMOD{C_CHECK_SEED}};
            default: begin
                for (int k = 0; k < NPMOD; k++) begin
                    w_seed[8*k +: 8] = 8'(k + 1);
                end
            end
        endcase
    end

    always_comb begin
        w_next = r_pattern;
        case (r_mode)
            MODE_WALK1: w_next = {r_pattern[PW-2:0], r_pattern[PW-1]};
            MODE_COUNT: w_next = r_pattern + C_ONE;
            MODE_CHECK: w_next = ~r_pattern;
            default:    w_next = r_pattern;
        endcase
    end

    // Seed reload lands one cycle after the mode change so it sees the new mode
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_ctr     <= '0;
            r_mode    <= MODE_WALK1;
            r_run     <= 1'b1;
            r_load    <= 1'b0;
            r_pattern <= C_ONE;
        end else begin
            r_ctr  <= r_ctr + CBITS'(1);
            r_load <= w_press[0];
            if (w_press[0]) begin
                r_mode <= mode_t'(r_mode + 2'd1);
            end
            if (w_press[1]) begin
                r_run <= ~r_run;
            end
            if (r_load) begin
                r_pattern <= w_seed;
            end else if (w_step && r_run && !w_press[0]) begin
                r_pattern <= w_next;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            bus.o_pmod <= C_ONE;
            bus.o_ledg <= 2'b00;
            bus.o_ledr <= 1'b0;
        end else begin
            bus.o_pmod <= r_pattern;
            bus.o_ledg <= {r_run, r_ctr[CBITS-1]};
            bus.o_ledr <= |w_stable;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pmod_pattern_gen.sv
// ============================================================================
//  tb_pmod_pattern_gen : directed vector bench for pmod_pattern_gen
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_pmod_pattern_gen;
    localparam int NPMOD = 2;
    localparam int PW    = 16;

    typedef struct {
        int          at_edge;
        logic        chk;
        logic [1:0]  btn_after;
        logic [15:0] pmod;
        logic        run;
        logic        ledr;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;
    vec_t tab1[$];
    vec_t tab2[$];

    always #5 clk = ~clk;

    pmod_pattern_gen_if #(.PW(PW)) bus ();

    pmod_pattern_gen #(
        .CBITS    (8),
        .STEPBITS (3),
        .DBBITS   (2),
        .NPMOD    (NPMOD)
    ) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Heartbeat LED shows bit 7 of the counter value before edge e
    task automatic apply(input vec_t v);
        logic [1:0] exp_ledg;
        while (cyc < v.at_edge) tick();
        if (v.chk) begin
            exp_ledg = {v.run, 1'(((v.at_edge - 1) >> 7) & 1)};
            check($sformatf("o_pmod@%0d", v.at_edge), 32'(bus.o_pmod), 32'(v.pmod));
            check($sformatf("o_ledg@%0d", v.at_edge), 32'(bus.o_ledg), 32'(exp_ledg));
            check($sformatf("o_ledr@%0d", v.at_edge), 32'(bus.o_ledr), 32'(v.ledr));
        end
        bus.i_btn = v.btn_after;
    endtask

    function automatic vec_t mk(int e, logic c, logic [1:0] b, logic [15:0] p, logic r, logic l);
        vec_t v;
        v.at_edge = e; v.chk = c; v.btn_after = b; v.pmod = p; v.run = r; v.ledr = l;
        return v;
    endfunction

    initial begin
        // WALK1 stepping and wrap
        tab1.push_back(mk(  1, 1, 2'b00, 16'h0001, 1, 0));
        tab1.push_back(mk(  8, 1, 2'b00, 16'h0001, 1, 0));
        tab1.push_back(mk(  9, 1, 2'b00, 16'h0002, 1, 0));
        tab1.push_back(mk( 17, 1, 2'b00, 16'h0004, 1, 0));
        tab1.push_back(mk(121, 1, 2'b00, 16'h8000, 1, 0));
        tab1.push_back(mk(129, 1, 2'b01, 16'h0001, 1, 0));
        // 3-clock glitch, then a real press into COUNT
        tab1.push_back(mk(132, 0, 2'b00, 16'h0000, 0, 0));
        tab1.push_back(mk(140, 1, 2'b01, 16'h0002, 1, 0));
        tab1.push_back(mk(147, 1, 2'b01, 16'h0004, 1, 1));
        tab1.push_back(mk(149, 1, 2'b01, 16'h0000, 1, 1));
        tab1.push_back(mk(152, 0, 2'b00, 16'h0000, 0, 0));
        tab1.push_back(mk(153, 1, 2'b00, 16'h0001, 1, 1));
        tab1.push_back(mk(161, 1, 2'b10, 16'h0002, 1, 0));
        // Pause, frozen, resume
        tab1.push_back(mk(169, 1, 2'b10, 16'h0003, 0, 1));
        tab1.push_back(mk(172, 0, 2'b00, 16'h0000, 0, 0));
        tab1.push_back(mk(233, 1, 2'b10, 16'h0003, 0, 0));
        tab1.push_back(mk(241, 1, 2'b10, 16'h0003, 1, 1));
        tab1.push_back(mk(245, 0, 2'b00, 16'h0000, 0, 0));
        tab1.push_back(mk(249, 1, 2'b01, 16'h0004, 1, 1));
        // CHECK: press coincides with a step, press wins
        tab1.push_back(mk(257, 1, 2'b01, 16'h0004, 1, 1));
        tab1.push_back(mk(258, 1, 2'b01, 16'h5555, 1, 1));
        tab1.push_back(mk(261, 0, 2'b00, 16'h0000, 0, 0));
        tab1.push_back(mk(265, 1, 2'b00, 16'hAAAA, 1, 1));
        tab1.push_back(mk(273, 1, 2'b01, 16'h5555, 1, 0));
        // PORTID static, then wrap to WALK1
        tab1.push_back(mk(282, 1, 2'b01, 16'h0201, 1, 1));
        tab1.push_back(mk(285, 0, 2'b00, 16'h0000, 0, 0));
        tab1.push_back(mk(300, 1, 2'b01, 16'h0201, 1, 0));
        tab1.push_back(mk(309, 1, 2'b01, 16'h0001, 1, 1));
        tab1.push_back(mk(312, 0, 2'b00, 16'h0000, 0, 0));
        tab1.push_back(mk(313, 1, 2'b00, 16'h0002, 1, 1));
        // Into COUNT and keep the button held
        tab1.push_back(mk(320, 1, 2'b01, 16'h0002, 1, 0));
        tab1.push_back(mk(328, 1, 2'b01, 16'h0004, 1, 1));
        tab1.push_back(mk(329, 1, 2'b01, 16'h0000, 1, 1));
        tab1.push_back(mk(337, 1, 2'b01, 16'h0001, 1, 1));
        tab1.push_back(mk(345, 1, 2'b01, 16'h0002, 1, 1));

        // After async reset with button 0 still held
        tab2.push_back(mk(  1, 1, 2'b01, 16'h0001, 1, 0));
        tab2.push_back(mk(  8, 1, 2'b01, 16'h0001, 1, 1));
        tab2.push_back(mk(  9, 1, 2'b01, 16'h0000, 1, 1));
        tab2.push_back(mk( 17, 1, 2'b01, 16'h0001, 1, 1));
        tab2.push_back(mk( 25, 1, 2'b00, 16'h0002, 1, 1));
        tab2.push_back(mk( 33, 1, 2'b00, 16'h0003, 1, 0));
        tab2.push_back(mk( 41, 1, 2'b00, 16'h0004, 1, 0));

        bus.i_btn = 2'b00;
        rst_n     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_pmod", 32'(bus.o_pmod), 32'h0001);
        check("reset_ledg", 32'(bus.o_ledg), 32'h0);
        check("reset_ledr", 32'(bus.o_ledr), 32'h0);
        rst_n = 1'b1;
        cyc   = 0;
        for (int i = 0; i < tab1.size(); i++) apply(tab1[i]);

        // Reset asserted between edges must act before the next edge
        #2;
        rst_n = 1'b0;
        #1;
        check("async_pmod", 32'(bus.o_pmod), 32'h0001);
        check("async_ledg", 32'(bus.o_ledg), 32'h0);
        check("async_ledr", 32'(bus.o_ledr), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
        for (int i = 0; i < tab2.size(); i++) apply(tab2[i]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
